// File: rtl/memgame_pkg.sv
// Shared types and constants for the memory card game datapath.
package memgame_pkg;

  localparam int GRID_W    = 6;
  localparam int GRID_H    = 6;
  localparam int NUM_CARDS = GRID_W * GRID_H;
  localparam int ADDR_W    = 6;

  typedef enum logic [2:0] {
    PICK1,
    PICK2,
    WAIT_CMP,
    SHOW,
    DONE
  } sel_state_t;

  localparam logic [1:0] PICK_NONE   = 2'd0;
  localparam logic [1:0] PICK_FIRST  = 2'd1;
  localparam logic [1:0] PICK_SECOND = 2'd2;

  function automatic logic [1:0] pick_code(input sel_state_t s);
    case (s)
      PICK1:   pick_code = PICK_FIRST;
      PICK2:   pick_code = PICK_SECOND;
      default: pick_code = PICK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a bank of synchronized button levels.
// History resets to all ones so a button held through reset is not a press.
module btn_edge #(
  parameter int WIDTH = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) prev <= '1;
    else          prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/card_select_ctrl.sv
// Cursor and card-selection front end of the memory game: moves a cursor over
// the board, issues two picks, waits for the comparator and tracks matches.
//
// state    | meaning
// ---------+------------------------------------------------------------
// PICK1    | cursor live, waiting for A on an unmatched card
// PICK2    | cursor live, waiting for A on a different unmatched card
// WAIT_CMP | both cards revealed, waiting for the comparator verdict
// SHOW     | mismatched pair held face-up for REVEAL_CYCLES cycles
// DONE     | every card matched; left only through reset
module card_select_ctrl #(
  parameter int GRID_W        = memgame_pkg::GRID_W,
  parameter int GRID_H        = memgame_pkg::GRID_H,
  parameter int ADDR_W        = memgame_pkg::ADDR_W,
  parameter int REVEAL_CYCLES = 50000000
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       btn_left,
  input  logic                       btn_right,
  input  logic                       btn_a,
  input  logic                       cmp_done,
  input  logic                       cmp_match,
  output logic [ADDR_W-1:0]          cursor_addr,
  output logic                       sel_pulse,
  output logic [1:0]                 input_state,
  output logic [ADDR_W-1:0]          card1_addr,
  output logic [ADDR_W-1:0]          card2_addr,
  output logic                       reveal,
  output logic [GRID_W*GRID_H-1:0]   matched_mask,
  output logic                       board_full
);

  import memgame_pkg::*;

  localparam int CARDS = GRID_W * GRID_H;
  localparam int CNT_W = $clog2(REVEAL_CYCLES + 1);
  localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(GRID_W - 1);
  localparam logic [ADDR_W-1:0] ROW_MAX = ADDR_W'(GRID_H - 1);

  sel_state_t        state, state_nxt;
  logic [ADDR_W-1:0] row, col, row_nxt, col_nxt, cursor_nxt;
  logic [ADDR_W-1:0] card1_nxt, card2_nxt;
  logic [CARDS-1:0]  mask_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [1:0]        pick_nxt;
  logic [4:0]        rise;
  logic              picking, sel_ok, accept;

  btn_edge #(.WIDTH(5)) u_btn_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .level   ({btn_a, btn_right, btn_left, btn_down, btn_up}),
    .rise    (rise)
  );

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    card1_nxt = card1_addr;
    card2_nxt = card2_addr;
    mask_nxt  = matched_mask;
    cnt_nxt   = cnt;

    picking = (state == PICK1) || (state == PICK2);
    sel_ok  = !matched_mask[cursor_addr] &&
              !((state == PICK2) && (cursor_addr == card1_addr));
    accept  = picking && rise[4] && sel_ok;

    // An A press in the same cycle as a move takes precedence; the move is lost.
    if (picking && !rise[4]) begin
      if (rise[0])      row_nxt = (row == '0) ? ROW_MAX : row - 1'b1;
      else if (rise[1]) row_nxt = (row == ROW_MAX) ? '0 : row + 1'b1;
      else if (rise[2]) col_nxt = (col == '0) ? COL_MAX : col - 1'b1;
      else if (rise[3]) col_nxt = (col == COL_MAX) ? '0 : col + 1'b1;
    end

    case (state)
      PICK1: begin
        if (accept) begin
          card1_nxt = cursor_addr;
          state_nxt = PICK2;
        end
      end
      PICK2: begin
        if (accept) begin
          card2_nxt = cursor_addr;
          state_nxt = WAIT_CMP;
        end
      end
      WAIT_CMP: begin
        if (cmp_done) begin
          if (cmp_match) begin
            mask_nxt[card1_addr] = 1'b1;
            mask_nxt[card2_addr] = 1'b1;
            state_nxt = (&mask_nxt) ? DONE : PICK1;
          end else begin
            cnt_nxt   = CNT_W'(REVEAL_CYCLES);
            state_nxt = SHOW;
          end
        end
      end
      SHOW: begin
        if (cnt == CNT_W'(1)) begin
          cnt_nxt   = '0;
          state_nxt = PICK1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DONE:    ;
      default: state_nxt = PICK1;
    endcase

    // During the select strobe the pick number reports the pick just made.
    pick_nxt   = accept ? pick_code(state) : pick_code(state_nxt);
    cursor_nxt = ADDR_W'(int'(row_nxt) * GRID_W + int'(col_nxt));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= PICK1;
      row          <= '0;
      col          <= '0;
      cursor_addr  <= '0;
      sel_pulse    <= 1'b0;
      input_state  <= PICK_FIRST;
      card1_addr   <= '0;
      card2_addr   <= '0;
      matched_mask <= '0;
      cnt          <= '0;
    end else begin
      state        <= state_nxt;
      row          <= row_nxt;
      col          <= col_nxt;
      cursor_addr  <= cursor_nxt;
      sel_pulse    <= accept;
      input_state  <= pick_nxt;
      card1_addr   <= card1_nxt;
      card2_addr   <= card2_nxt;
      matched_mask <= mask_nxt;
      cnt          <= cnt_nxt;
    end
  end

  assign reveal     = (state == WAIT_CMP) || (state == SHOW);
  assign board_full = (state == DONE);

endmodule

// File: tb/tb_card_select_ctrl.sv
// Self-checking bench for card_select_ctrl against a board-level game model.
module tb_card_select_ctrl;
  import memgame_pkg::*;

  localparam int RC = 4;
  localparam int NC = NUM_CARDS;
  localparam logic [4:0] B_UP = 5'b00001, B_DOWN = 5'b00010, B_LEFT = 5'b00100,
                         B_RIGHT = 5'b01000, B_A = 5'b10000;

  logic clock = 1'b0, reset_n = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_a = 1'b0;
  logic cmp_done = 1'b0, cmp_match = 1'b0;
  logic [ADDR_W-1:0] cursor_addr, card1_addr, card2_addr;
  logic sel_pulse, reveal, board_full;
  logic [1:0] input_state;
  logic [NC-1:0] matched_mask;

  int n_checks = 0, n_errors = 0;

  always #5 clock = ~clock;

  card_select_ctrl #(.GRID_W(GRID_W), .GRID_H(GRID_H), .ADDR_W(ADDR_W), .REVEAL_CYCLES(RC)) dut (
    .clock(clock), .reset_n(reset_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right), .btn_a(btn_a),
    .cmp_done(cmp_done), .cmp_match(cmp_match),
    .cursor_addr(cursor_addr), .sel_pulse(sel_pulse), .input_state(input_state),
    .card1_addr(card1_addr), .card2_addr(card2_addr), .reveal(reveal),
    .matched_mask(matched_mask), .board_full(board_full)
  );

  // Game model: cursor position, which pick is expected next (0 = none), matched cards.
  int m_row, m_col, m_stage, m_card1, m_card2;
  logic [NC-1:0] m_matched;
  bit m_waiting, m_done;

  function automatic int m_addr();
    return m_row * GRID_W + m_col;
  endfunction

  task automatic model_reset();
    m_row = 0; m_col = 0; m_stage = 1; m_card1 = 0; m_card2 = 0;
    m_matched = '0; m_waiting = 0; m_done = 0;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic set_btns(input logic [4:0] b);
    {btn_a, btn_right, btn_left, btn_down, btn_up} = b;
  endtask

  task automatic model_press(input logic [4:0] b, output logic ep, output logic [1:0] est);
    int addr;
    addr = m_addr();
    ep = 1'b0;
    est = 2'(m_stage);
    if (m_stage == 0) return;
    if (b[4]) begin
      if (!m_matched[addr] && !(m_stage == 2 && addr == m_card1)) begin
        ep = 1'b1;
        if (m_stage == 1) begin m_card1 = addr; m_stage = 2; end
        else begin m_card2 = addr; m_stage = 0; m_waiting = 1; end
      end
    end else if (b[0]) m_row = (m_row + GRID_H - 1) % GRID_H;
    else if (b[1]) m_row = (m_row + 1) % GRID_H;
    else if (b[2]) m_col = (m_col + GRID_W - 1) % GRID_W;
    else if (b[3]) m_col = (m_col + 1) % GRID_W;
  endtask

  // One press: hold for one cycle, sample the cycle after the event, release.
  task automatic act(input logic [4:0] b, output logic gp, output logic [1:0] gst,
                     output logic [ADDR_W-1:0] gca, output logic ep, output logic [1:0] est);
    model_press(b, ep, est);
    set_btns(b);
    tick();
    gp = sel_pulse; gst = input_state; gca = cursor_addr;
    set_btns(5'b0);
    tick();
  endtask

  task automatic goto(input int addr);
    logic gp, ep; logic [1:0] gst, est; logic [ADDR_W-1:0] gca;
    for (int k = 0; k < GRID_W && m_col != addr % GRID_W; k++) act(B_RIGHT, gp, gst, gca, ep, est);
    for (int k = 0; k < GRID_H && m_row != addr / GRID_W; k++) act(B_DOWN, gp, gst, gca, ep, est);
  endtask

  task automatic select(input int addr, output logic gp, output logic ep);
    logic [1:0] gst, est; logic [ADDR_W-1:0] gca;
    goto(addr);
    act(B_A, gp, gst, gca, ep, est);
  endtask

  task automatic cmp_pulse(input logic m);
    cmp_done = 1'b1; cmp_match = m;
    tick();
    cmp_done = 1'b0; cmp_match = 1'b0;
    if (m_waiting) begin
      m_waiting = 0;
      if (m) begin
        m_matched[m_card1] = 1'b1;
        m_matched[m_card2] = 1'b1;
        if (&m_matched) m_done = 1; else m_stage = 1;
      end
    end
  endtask

  // Counts reveal-high cycles after a mismatch verdict, toggling a button meanwhile.
  task automatic wait_show(output int n);
    n = 0;
    while (reveal && n < 20) begin
      n++;
      btn_right = n[0];
      tick();
    end
    btn_right = 1'b0;
    if (!m_done) m_stage = 1;
  endtask

  task automatic apply_reset();
    set_btns(5'b0); cmp_done = 1'b0; cmp_match = 1'b0;
    reset_n = 1'b0;
    #2;
    tick();
    reset_n = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (cursor_addr !== '0) begin n_errors++; $display("FAIL reset_cursor got=%0d exp=0", cursor_addr); end
    n_checks++; if (sel_pulse !== 1'b0) begin n_errors++; $display("FAIL reset_pulse got=%0b exp=0", sel_pulse); end
    n_checks++; if (input_state !== 2'd1) begin n_errors++; $display("FAIL reset_state got=%0d exp=1", input_state); end
    n_checks++; if (card1_addr !== '0 || card2_addr !== '0) begin n_errors++; $display("FAIL reset_cards got=%0d,%0d exp=0,0", card1_addr, card2_addr); end
    n_checks++; if (reveal !== 1'b0 || board_full !== 1'b0) begin n_errors++; $display("FAIL reset_flags got=%0b%0b exp=00", reveal, board_full); end
    n_checks++; if (matched_mask !== '0) begin n_errors++; $display("FAIL reset_mask got=%h exp=0", matched_mask); end
  endtask

  task automatic test_cursor();
    logic gp, ep; logic [1:0] gst, est; logic [ADDR_W-1:0] gca;
    logic [4:0] dirs [4];
    int exp_right [6], exp_down [6];
    dirs = '{B_UP, B_DOWN, B_LEFT, B_RIGHT};
    exp_right = '{1, 2, 3, 4, 5, 0};
    exp_down = '{6, 12, 18, 24, 30, 0};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      act(B_RIGHT, gp, gst, gca, ep, est);
      n_checks++; if (gca !== ADDR_W'(exp_right[i])) begin n_errors++; $display("FAIL right_wrap step=%0d got=%0d exp=%0d", i, gca, exp_right[i]); end
    end
    for (int i = 0; i < 6; i++) begin
      act(B_DOWN, gp, gst, gca, ep, est);
      n_checks++; if (gca !== ADDR_W'(exp_down[i])) begin n_errors++; $display("FAIL down_wrap step=%0d got=%0d exp=%0d", i, gca, exp_down[i]); end
    end
    act(B_LEFT, gp, gst, gca, ep, est);
    n_checks++; if (gca !== ADDR_W'(5)) begin n_errors++; $display("FAIL left_wrap got=%0d exp=5", gca); end
    act(B_RIGHT, gp, gst, gca, ep, est);
    act(B_UP, gp, gst, gca, ep, est);
    n_checks++; if (gca !== ADDR_W'(30)) begin n_errors++; $display("FAIL up_wrap got=%0d exp=30", gca); end
    for (int i = 0; i < 40; i++) begin
      logic [4:0] b;
      b = dirs[$urandom_range(3, 0)];
      if ($urandom_range(3, 0) == 0) b = b | dirs[$urandom_range(3, 0)];
      act(b, gp, gst, gca, ep, est);
      n_checks++; if (gca !== ADDR_W'(m_addr()) || gp !== 1'b0) begin n_errors++; $display("FAIL random_walk step=%0d btn=%b got=%0d exp=%0d", i, b, gca, m_addr()); end
    end
  endtask

  task automatic test_select_pair();
    logic gp, ep; logic [1:0] gst, est; logic [ADDR_W-1:0] gca;
    apply_reset();
    act(B_A, gp, gst, gca, ep, est);
    n_checks++; if (gp !== 1'b1 || gst !== 2'd1 || gca !== '0) begin n_errors++; $display("FAIL first_pick got=%0b/%0d/%0d exp=1/1/0", gp, gst, gca); end
    n_checks++; if (input_state !== 2'd2) begin n_errors++; $display("FAIL after_first got=%0d exp=2", input_state); end
    goto(7);
    act(B_A, gp, gst, gca, ep, est);
    n_checks++; if (gp !== 1'b1 || gst !== 2'd2 || gca !== ADDR_W'(7)) begin n_errors++; $display("FAIL second_pick got=%0b/%0d/%0d exp=1/2/7", gp, gst, gca); end
    n_checks++; if (card1_addr !== ADDR_W'(m_card1) || card2_addr !== ADDR_W'(m_card2) || reveal !== 1'b1 || input_state !== 2'd0) begin
      n_errors++; $display("FAIL wait_cmp got=%0d,%0d,%0b,%0d exp=%0d,%0d,1,0", card1_addr, card2_addr, reveal, input_state, m_card1, m_card2); end
    act(B_A, gp, gst, gca, ep, est);
    n_checks++; if (gp !== ep) begin n_errors++; $display("FAIL a_in_wait got=%0b exp=%0b", gp, ep); end
    act(B_RIGHT, gp, gst, gca, ep, est);
    n_checks++; if (gca !== ADDR_W'(m_addr())) begin n_errors++; $display("FAIL move_in_wait got=%0d exp=%0d", gca, m_addr()); end
  endtask

  task automatic test_match();
    logic gp, ep; logic [1:0] gst, est; logic [ADDR_W-1:0] gca;
    cmp_pulse(1'b1);
    n_checks++; if (matched_mask !== m_matched || input_state !== 2'd1 || reveal !== 1'b0) begin
      n_errors++; $display("FAIL match got=%h/%0d/%0b exp=%h/1/0", matched_mask, input_state, reveal, m_matched); end
    goto(0);
    act(B_A, gp, gst, gca, ep, est);
    n_checks++; if (gp !== ep || gst !== est) begin n_errors++; $display("FAIL matched0_pick got=%0b/%0d exp=%0b/%0d", gp, gst, ep, est); end
    goto(7);
    act(B_A, gp, gst, gca, ep, est);
    n_checks++; if (gp !== ep || input_state !== 2'(m_stage)) begin n_errors++; $display("FAIL matched7_pick got=%0b/%0d exp=%0b/%0d", gp, input_state, ep, m_stage); end
    cmp_pulse(1'b1);
    n_checks++; if (matched_mask !== m_matched || reveal !== 1'b0) begin n_errors++; $display("FAIL stray_cmp got=%h exp=%h", matched_mask, m_matched); end
  endtask

  task automatic test_mismatch();
    logic gp, ep; int n;
    select(1, gp, ep);
    select(2, gp, ep);
    n_checks++; if (gp !== 1'b1 || reveal !== 1'b1) begin n_errors++; $display("FAIL mm_select got=%0b/%0b exp=1/1", gp, reveal); end
    cmp_pulse(1'b0);
    wait_show(n);
    n_checks++; if (n != RC) begin n_errors++; $display("FAIL show_len got=%0d exp=%0d", n, RC); end
    n_checks++; if (cursor_addr !== ADDR_W'(m_addr()) || input_state !== 2'd1 || matched_mask !== m_matched) begin
      n_errors++; $display("FAIL after_show got=%0d/%0d/%h exp=%0d/1/%h", cursor_addr, input_state, matched_mask, m_addr(), m_matched); end
  endtask

  task automatic test_pick2_same();
    logic gp, ep; logic [1:0] gst, est; logic [ADDR_W-1:0] gca; int n;
    select(3, gp, ep);
    act(B_A, gp, gst, gca, ep, est);
    n_checks++; if (gp !== 1'b0 || ep !== 1'b0 || input_state !== 2'd2) begin n_errors++; $display("FAIL repeat_card1 got=%0b/%0d exp=0/2", gp, input_state); end
    act(B_RIGHT, gp, gst, gca, ep, est);
    act(B_A | B_RIGHT, gp, gst, gca, ep, est);
    n_checks++; if (gp !== 1'b1 || gca !== ADDR_W'(4) || card2_addr !== ADDR_W'(4) || gst !== 2'd2) begin
      n_errors++; $display("FAIL a_plus_right got=%0b/%0d/%0d exp=1/4/4", gp, gca, card2_addr); end
    cmp_pulse(1'b0);
    wait_show(n);
    n_checks++; if (n != RC || cursor_addr !== ADDR_W'(4)) begin n_errors++; $display("FAIL show2 got=%0d/%0d exp=%0d/4", n, cursor_addr, RC); end
  endtask

  task automatic test_board_full();
    int order [NC]; int n, tmp, j, bad;
    logic gp, ep; logic [1:0] gst, est; logic [ADDR_W-1:0] gca, hold;
    apply_reset();
    for (int i = 0; i < NC; i++) order[i] = i;
    for (int i = NC - 1; i > 0; i--) begin
      j = $urandom_range(i, 0); tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    bad = 0;
    for (int p = 0; p < NC / 2; p++) begin
      if ($urandom_range(3, 0) == 0) begin
        select(order[2*p], gp, ep); if (gp !== 1'b1) bad++;
        select(order[2*p+1], gp, ep); if (gp !== 1'b1) bad++;
        cmp_pulse(1'b0);
        wait_show(n); if (n != RC) bad++;
      end
      select(order[2*p], gp, ep); if (gp !== 1'b1) bad++;
      select(order[2*p+1], gp, ep); if (gp !== 1'b1) bad++;
      cmp_pulse(1'b1);
      if (matched_mask !== m_matched) bad++;
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL full_sequence errors=%0d exp=0", bad); end
    n_checks++; if (board_full !== 1'b1 || matched_mask !== '1 || input_state !== 2'd0 || reveal !== 1'b0) begin
      n_errors++; $display("FAIL board_full got=%0b/%h/%0d/%0b exp=1/all/0/0", board_full, matched_mask, input_state, reveal); end
    hold = cursor_addr;
    act(B_RIGHT, gp, gst, gca, ep, est);
    act(B_A, gp, gst, gca, ep, est);
    n_checks++; if (gp !== 1'b0 || gca !== hold || board_full !== 1'b1) begin n_errors++; $display("FAIL done_inert got=%0b/%0d exp=0/%0d", gp, gca, hold); end
  endtask

  task automatic test_reset_mid_show();
    logic gp, ep;
    apply_reset();
    select(5, gp, ep);
    select(11, gp, ep);
    cmp_pulse(1'b0);
    tick();
    n_checks++; if (reveal !== 1'b1) begin n_errors++; $display("FAIL pre_reset_show got=%0b exp=1", reveal); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (cursor_addr !== '0 || card1_addr !== '0 || card2_addr !== '0 || reveal !== 1'b0 || input_state !== 2'd1 || sel_pulse !== 1'b0 || matched_mask !== '0 || board_full !== 1'b0) begin
      n_errors++; $display("FAIL async_reset got=%0d/%0d/%0d/%0b/%0d exp=0/0/0/0/1", cursor_addr, card1_addr, card2_addr, reveal, input_state); end
    tick();
    reset_n = 1'b1;
    model_reset();
    tick();
  endtask

  initial begin
    test_reset();
    test_cursor();
    test_select_pair();
    test_match();
    test_mismatch();
    test_pick2_same();
    test_board_full();
    test_reset_mid_show();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/card_select_ctrl.md
Name: card_select_ctrl

Overview:
- Player-input front end of the memory card game; sits directly upstream of the card comparator stage.
- Turns debounced push-buttons into a cursor over the 6x6 board and issues first/second card selections (address, select pulse, pick number).
- Waits for the comparator's verdict, holds a mismatched pair face-up for a fixed time, and tracks which cards are already matched.

Parameters:
- GRID_W, 6, board columns.
- GRID_H, 6, board rows.
- ADDR_W, 6, card address width; must satisfy 2**ADDR_W >= GRID_W*GRID_H.
- REVEAL_CYCLES, 50000000, clock cycles a mismatched pair stays revealed (1 s at 50 MHz).

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- btn_up, btn_down, btn_left, btn_right, btn_a  in  1 each  synchronized, debounced button levels (1 = pressed).
- cmp_done  in  1  one-cycle pulse from the comparator: verdict valid.
- cmp_match  in  1  verdict, sampled only with cmp_done (1 = pair matches).
- cursor_addr  out  ADDR_W  registered; row*GRID_W+col; drives the card-memory read address.
- sel_pulse  out  1  one-cycle select strobe (the comparator's A).
- input_state  out  2  pick number: 1 = first card, 2 = second card, 0 = not picking.
- card1_addr, card2_addr  out  ADDR_W each  latched selections.
- reveal  out  1  both selected cards are shown face-up.
- matched_mask  out  GRID_W*GRID_H  bit i = card i is matched.
- board_full  out  1  all cards matched.

Behaviour:
- Reset (async, reset_n=0): state PICK1; row=col=0; cursor_addr=0; sel_pulse=0; input_state=1; card1_addr=card2_addr=0; reveal=0; matched_mask=0; board_full=0; reveal counter=0; button history regs=1.
  - Reset asserted mid-operation applies all of the above immediately.
  - Because history regs reset to 1, a button held through reset release counts as a press only after it is released and pressed again.
- Edge detection: a press event is cur & ~prev, one cycle wide.
  - Events are acted on only in PICK1/PICK2.
  - Events in any other state are discarded, not queued.
- Cursor movement:
  - Up and down change the row; left and right change the column.
  - The cursor wraps per axis: right at col 5 -> col 0, same row; down at row 5 -> row 0; left and up wrap the opposite way.
  - At most one move per cycle, priority up > down > left > right.
  - cursor_addr updates the cycle after the event.
- A event and a move event in the same cycle: the selection uses the current cursor and the move is dropped.
- States:
  - PICK1: A on an unmatched card -> card1_addr<=cursor, then PICK2.
  - PICK2: A on card1_addr or on a matched card is ignored. Any other card -> card2_addr<=cursor, then WAIT_CMP.
  - WAIT_CMP: waits indefinitely for cmp_done.
    - cmp_done with cmp_match=1 sets matched_mask bits card1_addr and card2_addr; next state is DONE if the mask is now all ones, else PICK1.
    - cmp_done with cmp_match=0 loads the counter and goes to SHOW.
  - SHOW: counter counts REVEAL_CYCLES cycles, then PICK1.
  - DONE: terminal; board_full=1; leaves only on reset.
- Output timing and values:
  - sel_pulse is registered and high for exactly the one cycle after an accepted A event.
  - In that pulse cycle, input_state = 1 or 2 (the pick just made) and cursor_addr = the selected address.
  - Outside the pulse cycle, input_state = 1 in PICK1, 2 in PICK2, 0 in WAIT_CMP/SHOW/DONE.
  - reveal=1 exactly in WAIT_CMP and SHOW.
  - In SHOW, reveal stays high for exactly REVEAL_CYCLES cycles.
- cmp_done arriving in any state other than WAIT_CMP is ignored.
- Rejected A events (matched card, repeat of card1) produce no pulse and no state change.

Decomposition:
- Shared package memgame_pkg:
  - constants GRID_W, GRID_H, NUM_CARDS=36, ADDR_W;
  - enum sel_state_t {PICK1, PICK2, WAIT_CMP, SHOW, DONE};
  - pick-number codes PICK_NONE=0, PICK_FIRST=1, PICK_SECOND=2.
- One sub-module btn_edge: parameterized-width rising-edge detector with async active-low reset, history resets to all ones. Instantiated once, 5 bits wide.

Test Plan (REVEAL_CYCLES=4):
- After reset, 6 right presses -> cursor_addr 1,2,3,4,5,0. From 0: 6 downs -> 6,12,18,24,30,0. Left at 0 -> 5; up from 0 -> 30.
- Select at 0, move to 7, select again:
  - first pulse carries input_state=1, cursor_addr=0;
  - second pulse carries input_state=2, cursor_addr=7;
  - card1_addr=0, card2_addr=7, reveal=1;
  - A pressed in WAIT_CMP gives no pulse.
- cmp_done=1 with cmp_match=1 -> matched_mask bits 0 and 7 set, PICK1 next cycle. A at 0 or 7 then gives no pulse.
- cmp_done=1 with cmp_match=0 -> reveal high exactly 4 cycles in SHOW, then input_state=1. Presses during SHOW leave cursor_addr unchanged.
- In PICK2 with cursor on card1, A gives no pulse. A+right in the same cycle selects the current card with no move.
- Match all 18 pairs -> board_full=1, further presses give no effect. Separately, pulling reset_n low mid-SHOW gives all reset values without a clock edge.
